// File: rtl/test_seq_pkg.sv
// -----------------------------------------------------------------------------
// test_seq_pkg
// Shared definitions for the test sequencer:
//   state_t      - sequencer FSM states
//   FC_*         - failure codes reported on fail_code
//   clog2_min1   - ceil(log2(n)) clamped to at least 1, for index widths
// -----------------------------------------------------------------------------
package test_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LAUNCH = 3'd1,
        ST_WAIT   = 3'd2,
        ST_PASS   = 3'd3,
        ST_FAIL   = 3'd4
    } state_t;

    localparam logic [1:0] FC_NONE      = 2'd0;
    localparam logic [1:0] FC_TEST_FAIL = 2'd1;
    localparam logic [1:0] FC_TIMEOUT   = 2'd2;
    localparam logic [1:0] FC_SPURIOUS  = 2'd3;

    // A single test still needs a 1-bit index.
    function automatic int clog2_min1(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/test_seq_watchdog.sv
// -----------------------------------------------------------------------------
// test_seq_watchdog
// Per-test cycle watchdog: a saturating up-counter with synchronous clear.
// Ports:
//   clk       in  clock
//   reset     in  asynchronous, active-low reset
//   i_clear   in  load 0 at the next edge (has priority over i_en)
//   i_en      in  count up by one per cycle, saturating at TIMEOUT_CYCLES
//   o_expired out high while the count equals TIMEOUT_CYCLES-1
// -----------------------------------------------------------------------------
module test_seq_watchdog #(
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int TMR_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clear,
    input  logic i_en,
    output logic o_expired
);

    localparam logic [TMR_W-1:0] CNT_MAX  = TMR_W'(TIMEOUT_CYCLES);
    localparam logic [TMR_W-1:0] CNT_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

    logic [TMR_W-1:0] r_count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_en && (r_count != CNT_MAX)) begin
            r_count <= r_count + TMR_W'(1);
        end
    end

    assign o_expired = (r_count == CNT_LAST);

endmodule

// File: rtl/test_sequencer.sv
// -----------------------------------------------------------------------------
// test_sequencer
// Runs NUM_TESTS sub-tests in order, one at a time, and reduces the outcome to
// sticky pass/fail levels, a failure code and the index of the failing test.
// Ports:
//   clk        in  clock
//   reset      in  asynchronous, active-low reset
//   go         in  start the sequence (only looked at in IDLE)
//   test_start out one-hot, single-cycle launch pulse for the active test
//   test_done  in  per-test completion (pulse or level)
//   test_fail  in  per-test failure flag
//   pass       out sticky, all tests completed without failure
//   fail       out sticky, sequence aborted
//   cur_test   out index of the active test, or of the failing test
//   fail_code  out FC_NONE / FC_TEST_FAIL / FC_TIMEOUT / FC_SPURIOUS
//   busy       out high while launching or waiting on a test
// -----------------------------------------------------------------------------
module test_sequencer
    import test_seq_pkg::*;
#(
    parameter int NUM_TESTS      = 4,
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int IDX_W          = clog2_min1(NUM_TESTS),
    parameter int TMR_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 go,
    output logic [NUM_TESTS-1:0] test_start,
    input  logic [NUM_TESTS-1:0] test_done,
    input  logic [NUM_TESTS-1:0] test_fail,
    output logic                 pass,
    output logic                 fail,
    output logic [IDX_W-1:0]     cur_test,
    output logic [1:0]           fail_code,
    output logic                 busy
);

    state_t               r_state;
    logic [IDX_W-1:0]     r_idx;
    logic [NUM_TESTS-1:0] r_test_start;
    logic                 r_pass;
    logic                 r_fail;
    logic [1:0]           r_fail_code;
    logic                 r_busy;

    logic [NUM_TESTS-1:0] w_sel;
    logic                 w_own_fail;
    logic                 w_own_done;
    logic                 w_spurious;
    logic                 w_last;
    logic                 w_expired;
    logic                 w_to_launch;
    logic                 w_wd_en;

    // One-hot decode of the active index.
    for (genvar gi = 0; gi < NUM_TESTS; gi++) begin : g_sel
        assign w_sel[gi] = (r_idx == IDX_W'(gi));
    end

    assign w_own_fail = |(test_fail & w_sel);
    assign w_own_done = |(test_done & w_sel);
    assign w_spurious = |((test_done | test_fail) & ~w_sel);
    assign w_last     = (r_idx == IDX_W'(NUM_TESTS - 1));

    // The watchdog is zeroed on the edge that enters LAUNCH, so it reads 0 in
    // the launch cycle and counts the launch cycle as part of the budget.
    assign w_to_launch = ((r_state == ST_IDLE) && go) ||
                         ((r_state == ST_WAIT) && !w_own_fail && w_own_done && !w_last);
    assign w_wd_en     = (r_state == ST_LAUNCH) || (r_state == ST_WAIT);

    test_seq_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .TMR_W         (TMR_W)
    ) u_watchdog (
        .clk      (clk),
        .reset    (reset),
        .i_clear  (w_to_launch),
        .i_en     (w_wd_en),
        .o_expired(w_expired)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= ST_IDLE;
            r_idx        <= '0;
            r_test_start <= '0;
            r_pass       <= 1'b0;
            r_fail       <= 1'b0;
            r_fail_code  <= FC_NONE;
            r_busy       <= 1'b0;
        end else begin
            r_test_start <= '0;
            case (r_state)
                ST_IDLE: begin
                    if (go) begin
                        r_idx        <= '0;
                        r_test_start <= NUM_TESTS'(1);
                        r_busy       <= 1'b1;
                        r_state      <= ST_LAUNCH;
                    end
                end
                ST_LAUNCH: begin
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    // Own failure beats own done; own done beats stray reports
                    // and an expiry in the same cycle.
                    if (w_own_fail) begin
                        r_fail      <= 1'b1;
                        r_fail_code <= FC_TEST_FAIL;
                        r_busy      <= 1'b0;
                        r_state     <= ST_FAIL;
                    end else if (w_own_done) begin
                        if (w_last) begin
                            r_pass  <= 1'b1;
                            r_busy  <= 1'b0;
                            r_state <= ST_PASS;
                        end else begin
                            r_idx        <= r_idx + IDX_W'(1);
                            r_test_start <= w_sel << 1;
                            r_state      <= ST_LAUNCH;
                        end
                    end else if (w_spurious) begin
                        r_fail      <= 1'b1;
                        r_fail_code <= FC_SPURIOUS;
                        r_busy      <= 1'b0;
                        r_state     <= ST_FAIL;
                    end else if (w_expired) begin
                        r_fail      <= 1'b1;
                        r_fail_code <= FC_TIMEOUT;
                        r_busy      <= 1'b0;
                        r_state     <= ST_FAIL;
                    end
                end
                ST_PASS, ST_FAIL: begin
                    // Terminal until reset.
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign test_start = r_test_start;
    assign pass       = r_pass;
    assign fail       = r_fail;
    assign cur_test   = r_idx;
    assign fail_code  = r_fail_code;
    assign busy       = r_busy;

endmodule

// File: tb/tb_test_sequencer.sv
// -----------------------------------------------------------------------------
// tb_test_sequencer
// Directed scenarios for test_sequencer with NUM_TESTS=4, TIMEOUT_CYCLES=10.
// Cycle numbering: the cycle after the edge that samples go is cycle 1.
// Inputs are driven 1 time unit after a rising edge; outputs are read there too.
// -----------------------------------------------------------------------------
module tb_test_sequencer;

    localparam int NT = 4;
    localparam int TO = 10;
    localparam int IW = 2;

    logic          clk       = 1'b0;
    logic          reset     = 1'b1;
    logic          go        = 1'b0;
    logic [NT-1:0] test_done = '0;
    logic [NT-1:0] test_fail = '0;
    logic [NT-1:0] test_start;
    logic          pass;
    logic          fail;
    logic          busy;
    logic [IW-1:0] cur_test;
    logic [1:0]    fail_code;

    int n_cmp = 0;
    int n_bad = 0;

    test_sequencer #(
        .NUM_TESTS     (NT),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .go        (go),
        .test_start(test_start),
        .test_done (test_done),
        .test_fail (test_fail),
        .pass      (pass),
        .fail      (fail),
        .cur_test  (cur_test),
        .fail_code (fail_code),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        go        = 1'b0;
        test_done = '0;
        test_fail = '0;
        reset     = 1'b0;
        step();
        step();
        reset = 1'b1;
        step();
    endtask

    task automatic test_reset();
        #2 reset = 1'b0;
        #2;
        n_cmp++; if (test_start !== 4'b0000) begin n_bad++; $display("FAIL reset_start: got %b want 0000", test_start); end
        n_cmp++; if (pass !== 1'b0) begin n_bad++; $display("FAIL reset_pass: got %b want 0", pass); end
        n_cmp++; if (fail !== 1'b0) begin n_bad++; $display("FAIL reset_fail: got %b want 0", fail); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (cur_test !== 2'd0) begin n_bad++; $display("FAIL reset_cur_test: got %0d want 0", cur_test); end
        n_cmp++; if (fail_code !== 2'd0) begin n_bad++; $display("FAIL reset_fail_code: got %0d want 0", fail_code); end
        step();
        reset = 1'b1;
        step();
        step();
        n_cmp++; if (busy !== 1'b0 || test_start !== 4'b0000) begin n_bad++; $display("FAIL idle_no_go: got busy=%b start=%b want 0/0000", busy, test_start); end
    endtask

    task automatic test_all_pass();
        logic [NT-1:0] exp_start;
        do_reset();
        go = 1'b1;   // held high throughout: ignored outside IDLE
        step();
        for (int c = 1; c <= 20; c++) begin
            exp_start = ((c - 1) % 4 == 0 && c <= 13) ? (NT'(1) << ((c - 1) / 4)) : '0;
            n_cmp++; if (test_start !== exp_start) begin n_bad++; $display("FAIL all_pass_start c%0d: got %b want %b", c, test_start, exp_start); end
            n_cmp++; if (pass !== (c >= 17)) begin n_bad++; $display("FAIL all_pass_pass c%0d: got %b want %b", c, pass, (c >= 17)); end
            n_cmp++; if (busy !== (c <= 16)) begin n_bad++; $display("FAIL all_pass_busy c%0d: got %b want %b", c, busy, (c <= 16)); end
            test_done = (c % 4 == 0 && c <= 16) ? (NT'(1) << (c / 4 - 1)) : '0;
            step();
        end
        go = 1'b0;
        test_done = '0;
        n_cmp++; if (fail !== 1'b0) begin n_bad++; $display("FAIL all_pass_fail: got %b want 0", fail); end
        n_cmp++; if (fail_code !== 2'd0) begin n_bad++; $display("FAIL all_pass_code: got %0d want 0", fail_code); end
    endtask

    task automatic test_test_fail();
        do_reset();
        go = 1'b1;
        step();
        go = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            if (c == 9) begin
                n_cmp++; if (test_start !== 4'b0100) begin n_bad++; $display("FAIL tfail_start2: got %b want 0100", test_start); end
            end
            test_done = (c == 4) ? 4'b0001 : (c == 8) ? 4'b0010 : (c == 12) ? 4'b0100 : 4'b0000;
            test_fail = (c == 12) ? 4'b0100 : 4'b0000;
            step();
        end
        test_done = '0;
        test_fail = '0;
        n_cmp++; if (fail !== 1'b1) begin n_bad++; $display("FAIL tfail_fail: got %b want 1", fail); end
        n_cmp++; if (pass !== 1'b0) begin n_bad++; $display("FAIL tfail_pass: got %b want 0", pass); end
        n_cmp++; if (cur_test !== 2'd2) begin n_bad++; $display("FAIL tfail_cur_test: got %0d want 2", cur_test); end
        n_cmp++; if (fail_code !== 2'd1) begin n_bad++; $display("FAIL tfail_code: got %0d want 1", fail_code); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL tfail_busy: got %b want 0", busy); end
        go = 1'b1;   // go in FAIL must not restart anything
        for (int c = 0; c < 10; c++) begin
            n_cmp++; if (test_start !== 4'b0000 || fail !== 1'b1) begin n_bad++; $display("FAIL tfail_hold +%0d: got start=%b fail=%b want 0000/1", c, test_start, fail); end
            step();
        end
        go = 1'b0;
    endtask

    task automatic test_timeout();
        do_reset();
        go = 1'b1;
        step();
        go = 1'b0;
        for (int c = 1; c <= 14; c++) begin
            if (c == 5) begin
                n_cmp++; if (test_start !== 4'b0010) begin n_bad++; $display("FAIL tmo_start1: got %b want 0010", test_start); end
            end
            if (c >= 6) begin
                n_cmp++; if (fail !== 1'b0 || busy !== 1'b1) begin n_bad++; $display("FAIL tmo_early c%0d: got fail=%b busy=%b want 0/1", c, fail, busy); end
            end
            test_done = (c == 4) ? 4'b0001 : 4'b0000;
            step();
        end
        // cycle 15: exactly 10 cycles after test_start[1]
        n_cmp++; if (fail !== 1'b1) begin n_bad++; $display("FAIL tmo_fail: got %b want 1", fail); end
        n_cmp++; if (cur_test !== 2'd1) begin n_bad++; $display("FAIL tmo_cur_test: got %0d want 1", cur_test); end
        n_cmp++; if (fail_code !== 2'd2) begin n_bad++; $display("FAIL tmo_code: got %0d want 2", fail_code); end
        n_cmp++; if (pass !== 1'b0) begin n_bad++; $display("FAIL tmo_pass: got %b want 0", pass); end
    endtask

    task automatic test_boundary();
        do_reset();
        go = 1'b1;
        step();
        go = 1'b0;
        for (int c = 1; c <= 22; c++) begin
            if (c == 15) begin
                n_cmp++; if (test_start !== 4'b0100 || fail !== 1'b0) begin n_bad++; $display("FAIL bnd_launch2: got start=%b fail=%b want 0100/0", test_start, fail); end
                n_cmp++; if (cur_test !== 2'd2) begin n_bad++; $display("FAIL bnd_cur_test: got %0d want 2", cur_test); end
            end
            if (c == 19) begin
                n_cmp++; if (test_start !== 4'b1000) begin n_bad++; $display("FAIL bnd_launch3: got %b want 1000", test_start); end
            end
            // test 1 (launched in cycle 5) answers on its expiry cycle 14
            test_done = (c == 4) ? 4'b0001 : (c == 14) ? 4'b0010 :
                        (c == 18) ? 4'b0100 : (c == 22) ? 4'b1000 : 4'b0000;
            step();
        end
        test_done = '0;
        n_cmp++; if (pass !== 1'b1 || fail !== 1'b0) begin n_bad++; $display("FAIL bnd_result: got pass=%b fail=%b want 1/0", pass, fail); end
        n_cmp++; if (fail_code !== 2'd0) begin n_bad++; $display("FAIL bnd_code: got %0d want 0", fail_code); end
    endtask

    task automatic test_spurious();
        do_reset();
        go = 1'b1;
        step();
        go = 1'b0;
        // cycle 1 (LAUNCH): a stray done is ignored here
        n_cmp++; if (test_start !== 4'b0001) begin n_bad++; $display("FAIL spur_start0: got %b want 0001", test_start); end
        test_done = 4'b1000;
        step();
        // cycle 2 (WAIT): stray done now sampled
        n_cmp++; if (fail !== 1'b0 || busy !== 1'b1) begin n_bad++; $display("FAIL spur_launch_ignore: got fail=%b busy=%b want 0/1", fail, busy); end
        step();
        test_done = '0;
        n_cmp++; if (fail !== 1'b1 || pass !== 1'b0) begin n_bad++; $display("FAIL spur_result: got fail=%b pass=%b want 1/0", fail, pass); end
        n_cmp++; if (cur_test !== 2'd0) begin n_bad++; $display("FAIL spur_cur_test: got %0d want 0", cur_test); end
        n_cmp++; if (fail_code !== 2'd3) begin n_bad++; $display("FAIL spur_code: got %0d want 3", fail_code); end
    endtask

    task automatic test_back_to_back();
        logic [NT-1:0] exp_start;
        do_reset();
        go = 1'b1;
        step();
        go = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            exp_start = (c % 2 == 1 && c <= 7) ? (NT'(1) << ((c - 1) / 2)) : '0;
            n_cmp++; if (test_start !== exp_start) begin n_bad++; $display("FAIL b2b_start c%0d: got %b want %b", c, test_start, exp_start); end
            n_cmp++; if (pass !== (c >= 9)) begin n_bad++; $display("FAIL b2b_pass c%0d: got %b want %b", c, pass, (c >= 9)); end
            test_done = (c % 2 == 0 && c <= 8) ? (NT'(1) << (c / 2 - 1)) : '0;
            step();
        end
        test_done = '0;
    endtask

    task automatic test_reset_mid_run();
        do_reset();
        go = 1'b1;
        step();
        go = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            test_done = (c == 4) ? 4'b0001 : 4'b0000;
            step();
        end
        // cycle 7: WAIT of test 1
        n_cmp++; if (busy !== 1'b1 || cur_test !== 2'd1) begin n_bad++; $display("FAIL mid_pre: got busy=%b cur=%0d want 1/1", busy, cur_test); end
        #1 reset = 1'b0;
        #1;
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL mid_async_busy: got %b want 0", busy); end
        n_cmp++; if (cur_test !== 2'd0) begin n_bad++; $display("FAIL mid_async_cur: got %0d want 0", cur_test); end
        n_cmp++; if (pass !== 1'b0 || fail !== 1'b0) begin n_bad++; $display("FAIL mid_async_pf: got pass=%b fail=%b want 0/0", pass, fail); end
        n_cmp++; if (test_start !== 4'b0000 || fail_code !== 2'd0) begin n_bad++; $display("FAIL mid_async_misc: got start=%b code=%0d want 0000/0", test_start, fail_code); end
        step();
        step();
        reset = 1'b1;
        step();
        n_cmp++; if (fail !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL mid_silent: got fail=%b busy=%b want 0/0", fail, busy); end
        go = 1'b1;
        step();
        go = 1'b0;
        n_cmp++; if (test_start !== 4'b0001 || cur_test !== 2'd0) begin n_bad++; $display("FAIL mid_restart: got start=%b cur=%0d want 0001/0", test_start, cur_test); end
        for (int c = 1; c <= 16; c++) begin
            test_done = (c % 4 == 0) ? (NT'(1) << (c / 4 - 1)) : '0;
            step();
        end
        test_done = '0;
        n_cmp++; if (pass !== 1'b1 || fail !== 1'b0) begin n_bad++; $display("FAIL mid_rerun: got pass=%b fail=%b want 1/0", pass, fail); end
    endtask

    initial begin
        #100000;
        $display("FAIL global_time_limit: simulation did not finish");
        $fatal(1, "time limit");
    end

    initial begin
        test_reset();
        test_all_pass();
        test_test_fail();
        test_timeout();
        test_boundary();
        test_spurious();
        test_back_to_back();
        test_reset_mid_run();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
